// File: rtl/rf_wb_ctrl_pkg.sv
// Shared widths and source-select encoding for the writeback controller.
package rf_wb_ctrl_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  // Writeback source select; also used as the round-robin last-grant pointer.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  // One writeback request as seen by the arbiter.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for x1..x31 with one set port, one clear port
// and two combinational lookup ports. x0 is never pending.
module rf_scoreboard
  import rf_wb_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_set_en,
  input  logic [REG_ADDR_W-1:0] i_set_rd,
  input  logic                  i_clr_en,
  input  logic [REG_ADDR_W-1:0] i_clr_rd,
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  output logic                  o_rs1_pend,
  output logic                  o_rs2_pend
);

  logic [NUM_REGS-1:0] r_pend;
  logic [NUM_REGS-1:0] w_pend_nxt;

  // Next pending vector: clear first so a same-edge set on the same register wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_clr_en) w_pend_nxt[i_clr_rd] = 1'b0;
    if (i_set_en) w_pend_nxt[i_set_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  // Pending state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= w_pend_nxt;
  end

  // Bit 0 is held at zero, so lookups of x0 never report pending.
  assign o_rs1_pend = r_pend[i_rs1];
  assign o_rs2_pend = r_pend[i_rs2];

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file writeback controller: arbitrates ALU and LSU writeback
// requests onto a single registered write port and tracks pending
// destination registers to raise a RAW stall in decode.
module rf_wb_ctrl
  import rf_wb_ctrl_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_alu_valid,
  input  logic [REG_ADDR_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]       i_alu_data,
  output logic                  o_alu_ready,
  input  logic                  i_lsu_valid,
  input  logic [REG_ADDR_W-1:0] i_lsu_rd,
  input  logic [XLEN-1:0]       i_lsu_data,
  output logic                  o_lsu_ready,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  output logic                  o_stall,
  output logic                  o_rf_wr,
  output logic [REG_ADDR_W-1:0] o_rf_rd,
  output logic [XLEN-1:0]       o_rf_wdata
);

  src_e                  r_last;
  logic                  r_wr;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_wdata;

  logic                  w_gnt_alu;
  logic                  w_gnt_lsu;
  logic                  w_xfer;
  src_e                  w_src;
  wb_req_t               w_win;
  logic                  w_commit;
  logic                  w_rs1_pend;
  logic                  w_rs2_pend;

  // Arbitration: a lone requester wins; on contention RR picks the source
  // that was not granted last, fixed priority always picks the LSU.
  always_comb begin
    w_gnt_alu = 1'b0;
    w_gnt_lsu = 1'b0;
    if (i_alu_valid && i_lsu_valid) begin
      if ((RR_EN != 0) && (r_last == SRC_LSU)) w_gnt_alu = 1'b1;
      else                                     w_gnt_lsu = 1'b1;
    end else begin
      w_gnt_alu = i_alu_valid;
      w_gnt_lsu = i_lsu_valid;
    end
  end

  // Nothing is accepted while reset is held.
  assign o_alu_ready = w_gnt_alu && rst_n;
  assign o_lsu_ready = w_gnt_lsu && rst_n;
  assign w_xfer      = o_alu_ready || o_lsu_ready;
  assign w_src       = o_lsu_ready ? SRC_LSU : SRC_ALU;

  // Winning request payload.
  always_comb begin
    w_win.rd   = i_alu_rd;
    w_win.data = i_alu_data;
    if (w_src == SRC_LSU) begin
      w_win.rd   = i_lsu_rd;
      w_win.data = i_lsu_data;
    end
  end

  // x0 writes complete the handshake but never reach the register file.
  assign w_commit = w_xfer && (w_win.rd != '0);

  // Last-grant pointer moves only when a transfer actually happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_last <= SRC_ALU;
    else if (w_xfer) r_last <= w_src;
  end

  // Registered write port: one-cycle write strobe, address/data held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= 1'b0;
      r_rd    <= '0;
      r_wdata <= '0;
    end else begin
      r_wr <= w_commit;
      if (w_commit) begin
        r_rd    <= w_win.rd;
        r_wdata <= w_win.data;
      end
    end
  end

  assign o_rf_wr    = r_wr;
  assign o_rf_rd    = r_rd;
  assign o_rf_wdata = r_wdata;

  rf_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_en   (i_issue_valid),
    .i_set_rd   (i_issue_rd),
    .i_clr_en   (r_wr),
    .i_clr_rd   (r_rd),
    .i_rs1      (i_rs1),
    .i_rs2      (i_rs2),
    .o_rs1_pend (w_rs1_pend),
    .o_rs2_pend (w_rs2_pend)
  );

  // No bypass: stall holds until the pending bit clears after the write.
  assign o_stall = ((i_rs1 != '0) && w_rs1_pend) || ((i_rs2 != '0) && w_rs2_pend);

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Bench for rf_wb_ctrl: a round-robin and a fixed-priority instance share
// stimulus; a reference model predicts handshakes, stalls and writebacks,
// and a monitor pops expected writes from per-instance queues.
module tb_rf_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_v, lsu_v, iss_v;
  logic [4:0]  alu_rd, lsu_rd, iss_rd, rs1, rs2;
  logic [31:0] alu_d, lsu_d;

  logic        alu_rdy [2];
  logic        lsu_rdy [2];
  logic        stall   [2];
  logic        rf_wr   [2];
  logic [4:0]  rf_rd   [2];
  logic [31:0] rf_wd   [2];

  always #5 clk = ~clk;

  rf_wb_ctrl #(.RR_EN(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .i_alu_valid(alu_v), .i_alu_rd(alu_rd), .i_alu_data(alu_d), .o_alu_ready(alu_rdy[0]),
    .i_lsu_valid(lsu_v), .i_lsu_rd(lsu_rd), .i_lsu_data(lsu_d), .o_lsu_ready(lsu_rdy[0]),
    .i_issue_valid(iss_v), .i_issue_rd(iss_rd), .i_rs1(rs1), .i_rs2(rs2),
    .o_stall(stall[0]), .o_rf_wr(rf_wr[0]), .o_rf_rd(rf_rd[0]), .o_rf_wdata(rf_wd[0])
  );

  rf_wb_ctrl #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .i_alu_valid(alu_v), .i_alu_rd(alu_rd), .i_alu_data(alu_d), .o_alu_ready(alu_rdy[1]),
    .i_lsu_valid(lsu_v), .i_lsu_rd(lsu_rd), .i_lsu_data(lsu_d), .o_lsu_ready(lsu_rdy[1]),
    .i_issue_valid(iss_v), .i_issue_rd(iss_rd), .i_rs1(rs1), .i_rs2(rs2),
    .o_stall(stall[1]), .o_rf_wr(rf_wr[1]), .o_rf_rd(rf_rd[1]), .o_rf_wdata(rf_wd[1])
  );

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;

  // Reference model state, index 0 = round-robin, 1 = fixed priority.
  wb_t         wbq [2][$];
  bit          pend [2][32];
  int          last [2];        // 0 = ALU granted last, 1 = LSU
  bit          ew_v [2];        // write the model expects committing this cycle
  logic [4:0]  ew_rd [2];
  bit          nw_v [2];
  logic [4:0]  nw_rd [2];
  int          nlast [2];
  bit          nxf [2];
  logic [4:0]  hold_rd [2];
  logic [31:0] hold_wd [2];

  logic        obs_a [2];
  logic        obs_l [2];
  logic        obs_s [2];

  wb_t         mon_e;

  task automatic chk(input string n, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d actual=%0h expected=%0h", n, d, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      wbq[d].delete();
      for (int r = 0; r < 32; r++) pend[d][r] = 1'b0;
      last[d]    = 0;
      ew_v[d]    = 1'b0;
      ew_rd[d]   = '0;
      hold_rd[d] = '0;
      hold_wd[d] = '0;
    end
  endtask

  // One cycle: drive inputs just after a rising edge, check at the falling
  // edge, advance the model at the next rising edge.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic iv, input logic [4:0] ird,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic ea, el, es, alu_wins;
    wb_t  w;
    alu_v = av; alu_rd = ard; alu_d = ad;
    lsu_v = lv; lsu_rd = lrd; lsu_d = ld;
    iss_v = iv; iss_rd = ird; rs1 = r1; rs2 = r2;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (av && lv) begin
        alu_wins = (d == 0) && (last[d] == 1);
        ea = alu_wins;
        el = !alu_wins;
      end else begin
        ea = av;
        el = lv;
      end
      es = ((r1 != 0) && pend[d][r1]) || ((r2 != 0) && pend[d][r2]);
      obs_a[d] = alu_rdy[d];
      obs_l[d] = lsu_rdy[d];
      obs_s[d] = stall[d];
      chk("alu_ready", d, alu_rdy[d], ea);
      chk("lsu_ready", d, lsu_rdy[d], el);
      chk("stall", d, stall[d], es);
      nxf[d]   = ea || el;
      nlast[d] = ea ? 0 : 1;
      w.cyc    = cyc + 1;
      w.rd     = ea ? ard : lrd;
      w.data   = ea ? ad : ld;
      nw_v[d]  = nxf[d] && (w.rd != 0);
      nw_rd[d] = w.rd;
      if (nw_v[d]) wbq[d].push_back(w);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (ew_v[d]) pend[d][ew_rd[d]] = 1'b0;
      if (iv && ird != 0) pend[d][ird] = 1'b1;
      ew_v[d]  = nw_v[d];
      ew_rd[d] = nw_rd[d];
      if (nxf[d]) last[d] = nlast[d];
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  // Writeback monitor: every falling edge out of reset, each instance either
  // commits the write the model queued for this cycle or holds its port.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (wbq[d].size() > 0 && wbq[d][0].cyc == cyc) begin
          mon_e = wbq[d].pop_front();
          chk("rf_wr", d, rf_wr[d], 1);
          chk("rf_rd", d, rf_rd[d], mon_e.rd);
          chk("rf_wdata", d, rf_wd[d], mon_e.data);
          hold_rd[d] = mon_e.rd;
          hold_wd[d] = mon_e.data;
        end else begin
          chk("rf_wr_idle", d, rf_wr[d], 0);
          chk("rf_rd_hold", d, rf_rd[d], hold_rd[d]);
          chk("rf_wdata_hold", d, rf_wd[d], hold_wd[d]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    alu_v = 1; alu_rd = 3; alu_d = 32'hdead_beef;
    lsu_v = 1; lsu_rd = 4; lsu_d = 32'hcafe_f00d;
    iss_v = 0; iss_rd = 0; rs1 = 3; rs2 = 4;
    model_reset();
    #3;
    for (int d = 0; d < 2; d++) begin
      chk("rst_rf_wr", d, rf_wr[d], 0);
      chk("rst_rf_rd", d, rf_rd[d], 0);
      chk("rst_rf_wdata", d, rf_wd[d], 0);
      chk("rst_stall", d, stall[d], 0);
      chk("rst_alu_ready", d, alu_rdy[d], 0);
      chk("rst_lsu_ready", d, lsu_rdy[d], 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Lone ALU write to x5: accepted now, written next cycle only.
    step(1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0);
    for (int d = 0; d < 2; d++) chk("alu_alone_ready", d, obs_a[d], 1);
    idle(0, 0);
    idle(0, 0);

    // Four cycles of contention.
    for (int k = 0; k < 4; k++) begin
      step(1, 5'(1 + k), 32'(32'h100 + k), 1, 5'(11 + k), 32'(32'h200 + k), 0, 0, 0, 0);
      chk("contend_rr_lsu", 0, obs_l[0], (k % 2 == 0) ? 1 : 0);
      chk("contend_fp_lsu", 1, obs_l[1], 1);
    end
    idle(0, 0);

    // RAW on x7 until the write commits; x0 sources never stall.
    step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    idle(7, 0);
    for (int d = 0; d < 2; d++) chk("raw_x7_stall", d, obs_s[d], 1);
    idle(0, 0);
    for (int d = 0; d < 2; d++) chk("x0_no_stall", d, obs_s[d], 0);
    step(1, 7, 32'h0000_0777, 0, 0, 0, 0, 0, 7, 0);
    for (int d = 0; d < 2; d++) chk("raw_x7_xfer_stall", d, obs_s[d], 1);
    idle(7, 0);
    for (int d = 0; d < 2; d++) chk("raw_x7_commit_stall", d, obs_s[d], 1);
    idle(7, 0);
    for (int d = 0; d < 2; d++) chk("raw_x7_released", d, obs_s[d], 0);

    // Same-edge commit and re-issue of x9: set wins.
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    step(1, 9, 32'h0000_0999, 0, 0, 0, 0, 0, 0, 9);
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
    idle(0, 9);
    for (int d = 0; d < 2; d++) chk("x9_set_wins_stall", d, obs_s[d], 1);
    step(1, 9, 32'h0000_0998, 0, 0, 0, 0, 0, 0, 9);
    idle(0, 9);
    idle(0, 9);
    for (int d = 0; d < 2; d++) chk("x9_released", d, obs_s[d], 0);

    // LSU return to x0: handshake only, pending x3 untouched.
    step(0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    step(0, 0, 0, 1, 0, 32'hffff_ffff, 0, 0, 3, 0);
    for (int d = 0; d < 2; d++) chk("x0_lsu_ready", d, obs_l[d], 1);
    idle(3, 0);
    idle(3, 0);
    for (int d = 0; d < 2; d++) chk("x0_sb_unchanged", d, obs_s[d], 1);

    // Reset pulse in the cycle after a grant: write dropped, state cleared.
    step(1, 12, 32'haaaa_0001, 1, 13, 32'hbbbb_0002, 0, 0, 0, 0);
    step(1, 14, 32'haaaa_0003, 1, 15, 32'hbbbb_0004, 0, 0, 0, 0);
    rst_n = 1'b0;
    rs1 = 3;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("midrst_rf_wr", d, rf_wr[d], 0);
      chk("midrst_rf_rd", d, rf_rd[d], 0);
      chk("midrst_stall", d, stall[d], 0);
      chk("midrst_alu_ready", d, alu_rdy[d], 0);
      chk("midrst_lsu_ready", d, lsu_rdy[d], 0);
    end
    model_reset();
    alu_v = 0; lsu_v = 0; iss_v = 0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    step(1, 16, 32'h1616_1616, 1, 17, 32'h1717_1717, 0, 0, 0, 0);
    for (int d = 0; d < 2; d++) chk("post_rst_lsu_first", d, obs_l[d], 1);

    // Randomized traffic, register numbers kept small to force hazards.
    for (int k = 0; k < 2000; k++) begin
      step($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(0, 0);
    idle(0, 0);
    for (int d = 0; d < 2; d++) chk("queue_drained", d, wbq[d].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_ctrl.md
RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

Interface
REQ-001 SHALL have parameter RR_EN, default 1; 1 = round-robin arbitration, 0 = fixed priority with LSU first.
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port i_alu_valid, input, 1, ALU writeback request.
REQ-005 SHALL have port i_alu_rd, input, 5, ALU destination register.
REQ-006 SHALL have port i_alu_data, input, 32, ALU result.
REQ-007 SHALL have port o_alu_ready, output, 1, ALU request accepted this cycle.
REQ-008 SHALL have ports i_lsu_valid (input, 1), i_lsu_rd (input, 5), i_lsu_data (input, 32) and o_lsu_ready (output, 1), with the same meanings for load return.
REQ-009 SHALL have port i_issue_valid, input, 1, instruction issued that will write a register.
REQ-010 SHALL have port i_issue_rd, input, 5, destination register of the issued instruction.
REQ-011 SHALL have ports i_rs1 and i_rs2, input, 5 each, source registers of the instruction in decode.
REQ-012 SHALL have port o_stall, output, 1, RAW hazard on a pending register.
REQ-013 SHALL have port o_rf_wr, output, 1, register-file write enable.
REQ-014 SHALL have port o_rf_rd, output, 5, register-file write address.
REQ-015 SHALL have port o_rf_wdata, output, 32, register-file write data.

Function
REQ-016 SHALL complete a transfer on a requester when valid && ready are both high in the same cycle.
REQ-017 SHALL derive ready combinationally: a lone valid requester is ready; when both are valid, only the winner is ready; no requester is ever ready without valid.
REQ-018 With RR_EN=1, SHALL grant the non-last-granted source on contention, update the last-grant pointer only on a transfer, and treat LSU as last-granted=ALU after reset.
REQ-019 With RR_EN=0, SHALL grant LSU on every contention.
REQ-020 SHALL register the winning rd/data: transfer in cycle N drives o_rf_wr=1 with o_rf_rd/o_rf_wdata in cycle N+1, for exactly one cycle per transfer.
REQ-021 SHALL accept a transfer with rd=0 (handshake completes), but SHALL hold o_rf_wr low for it and leave the scoreboard unchanged.
REQ-022 SHALL hold o_rf_rd/o_rf_wdata at their last values while o_rf_wr=0.
REQ-023 SHALL keep a 31-bit pending scoreboard for x1..x31; i_issue_valid with rd!=0 sets the bit at the clock edge.
REQ-024 SHALL clear pending[o_rf_rd] at the edge ending a cycle in which o_rf_wr=1.
REQ-025 When a set and a clear hit the same register at one edge, set SHALL win.
REQ-026 SHALL compute o_stall combinationally as (rs1!=0 && pending[rs1]) || (rs2!=0 && pending[rs2]); x0 never stalls.
REQ-027 SHALL perform no bypassing: stall deasserts in the cycle after the write commits.

Reset
REQ-028 During rst_n=0, o_rf_wr=0, o_rf_rd=0, o_rf_wdata=0, the scoreboard is cleared (o_stall=0), and the RR pointer is reset.
REQ-029 Reset asserted mid-operation SHALL drop any registered write in flight; o_alu_ready and o_lsu_ready SHALL be 0 while rst_n=0.

Structure
REQ-030 SHALL place the widths XLEN=32 and REG_ADDR_W=5 and the source-select encoding (SRC_ALU=0, SRC_LSU=1) in the shared core package.
REQ-031 SHALL implement the scoreboard as sub-module rf_scoreboard (set port, clear port, two lookup ports); arbitration and the output register live in the top module.

Verification
REQ-032 ALU alone, rd=5, data 0x1234_5678 in cycle 0 -> o_alu_ready=1 in cycle 0; o_rf_wr=1, o_rf_rd=5, o_rf_wdata=0x1234_5678 in cycle 1 only.
REQ-033 Both valid for 4 cycles with RR_EN=1 -> grants LSU, ALU, LSU, ALU; with RR_EN=0 -> LSU on all 4.
REQ-034 Issue rd=7, then rs1=7 in decode -> o_stall=1 until the write to x7 commits, then 0 on the following cycle; rs1=0 -> o_stall=0 throughout.
REQ-035 Same-edge write-commit to x9 and new issue rd=9 -> pending[9] stays 1 and o_stall remains 1 for rs2=9.
REQ-036 LSU transfer with rd=0 -> o_lsu_ready=1, o_rf_wr remains 0, scoreboard unchanged.
REQ-037 rst_n pulsed low during the cycle after a grant -> o_rf_wr=0 immediately, all pending bits cleared, first contention after release grants LSU.
